// File: rtl/if_fetch_if.sv
// Fetch-unit bundle: PC handshake, byte-wide memory read port and decode handoff.
// master is the fetch unit; slave is the PC/memory/decode side.
interface if_fetch_if;
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 16;
    localparam int unsigned BW = 8;

    logic [AW-1:0] pc_addr;
    logic          pc_en;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [BW-1:0] mem_rdata;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_addr;
    logic          inst_ready;

    modport master (
        input  pc_addr, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        output pc_en, mem_req, mem_addr, inst_valid, inst, inst_addr
    );

    modport slave (
        output pc_addr, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        input  pc_en, mem_req, mem_addr, inst_valid, inst, inst_addr
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 16-bit instruction from two byte reads,
// holds it for decode, and redirects (draining any in-flight read) on flush.
module if_fetch #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned IW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        HOLD    = 3'd5,
        DRAIN   = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [BW-1:0] lo_byte_q, lo_byte_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] inst_addr_q, inst_addr_d;
    logic          in_flight_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            lo_byte_q    <= '0;
            inst_q       <= '0;
            inst_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            lo_byte_q    <= lo_byte_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
        end
    end

    // A read is still owed to us if granted now or waiting without rvalid.
    always_comb begin
        in_flight_c = 1'b0;
        case (state_q)
            REQ_LO, REQ_HI:          in_flight_c = bus.mem_gnt;
            WAIT_LO, WAIT_HI, DRAIN: in_flight_c = !bus.mem_rvalid;
            default:                 in_flight_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        lo_byte_d    = lo_byte_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        case (state_q)
            IDLE: state_d = REQ_LO;
            REQ_LO: begin
                if (bus.mem_gnt) begin
                    state_d      = WAIT_LO;
                    fetch_addr_d = bus.pc_addr;
                end
            end
            WAIT_LO: begin
                if (bus.mem_rvalid) begin
                    state_d   = REQ_HI;
                    lo_byte_d = bus.mem_rdata;
                end
            end
            REQ_HI: begin
                if (bus.mem_gnt) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.mem_rvalid) begin
                    state_d     = HOLD;
                    inst_d      = BIG_ENDIAN ? {lo_byte_q, bus.mem_rdata}
                                             : {bus.mem_rdata, lo_byte_q};
                    inst_addr_d = fetch_addr_q;
                end
            end
            HOLD: begin
                if (bus.inst_ready) state_d = REQ_LO;
            end
            DRAIN: begin
                if (bus.mem_rvalid) state_d = REQ_LO;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything; no datapath register may capture this cycle.
        if (bus.flush) begin
            fetch_addr_d = fetch_addr_q;
            lo_byte_d    = lo_byte_q;
            inst_d       = inst_q;
            inst_addr_d  = inst_addr_q;
            state_d      = in_flight_c ? DRAIN : REQ_LO;
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_addr   = bus.pc_addr;
        bus.pc_en      = 1'b0;
        bus.inst_valid = 1'b0;
        case (state_q)
            REQ_LO: bus.mem_req = 1'b1;
            REQ_HI: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = fetch_addr_q + AW'(1);
            end
            WAIT_HI: bus.pc_en      = bus.mem_rvalid;
            HOLD:    bus.inst_valid = 1'b1;
            default: bus.mem_req    = 1'b0;
        endcase
        if (bus.flush) begin
            bus.pc_en      = 1'b1;
            bus.inst_valid = 1'b0;
        end
        if (!rst) begin
            bus.mem_req    = 1'b0;
            bus.pc_en      = 1'b0;
            bus.inst_valid = 1'b0;
        end
    end

    assign bus.inst      = inst_q;
    assign bus.inst_addr = inst_addr_q;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: little- and big-endian instances run in lockstep
// against a byte memory that returns rvalid the cycle after grant.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_if ifc0 ();
    if_fetch_if ifc1 ();

    if_fetch #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst(rst), .bus(ifc0));
    if_fetch #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst(rst), .bus(ifc1));

    assign ifc1.pc_addr    = ifc0.pc_addr;
    assign ifc1.flush      = ifc0.flush;
    assign ifc1.mem_gnt    = ifc0.mem_gnt;
    assign ifc1.mem_rvalid = ifc0.mem_rvalid;
    assign ifc1.mem_rdata  = ifc0.mem_rdata;
    assign ifc1.inst_ready = ifc0.inst_ready;

    int          checks = 0;
    int          errors = 0;
    logic        pend;
    logic [15:0] pend_addr;
    logic [15:0] target;
    logic        rv_hold;
    logic [7:0]  mem [logic [15:0]];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        ifc0.mem_rvalid = pend && !rv_hold;
        ifc0.mem_rdata  = (pend && mem.exists(pend_addr)) ? mem[pend_addr] : 8'h00;
    endtask

    // One clock: PC register and memory responder react to what was seen before the edge.
    task automatic tick();
        logic        en, fl, fire, done;
        logic [15:0] a;
        #1;
        en   = ifc0.pc_en;
        fl   = ifc0.flush;
        fire = ifc0.mem_req && ifc0.mem_gnt;
        a    = ifc0.mem_addr;
        done = ifc0.mem_rvalid;
        @(posedge clk);
        #1;
        if (en) ifc0.pc_addr = fl ? target : ifc0.pc_addr + 16'd2;
        if (done) pend = 1'b0;
        if (fire) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        mem_drive();
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        pend            = 1'b0;
        pend_addr       = 16'h0000;
        rv_hold         = 1'b0;
        target          = 16'h0000;
        ifc0.pc_addr    = 16'h0000;
        ifc0.flush      = 1'b0;
        ifc0.mem_gnt    = 1'b1;
        ifc0.mem_rvalid = 1'b0;
        ifc0.mem_rdata  = 8'h00;
        ifc0.inst_ready = 1'b0;
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        mem[16'h0002] = 8'h78;
        mem[16'h0003] = 8'h56;
        mem[16'h0040] = 8'h11;
        mem[16'h0041] = 8'h22;
        mem[16'h0080] = 8'hEF;
        mem[16'h0081] = 8'hBE;
        mem[16'hFFFF] = 8'hAB;

        tick();
        tick();
        chk("rst_mem_req",    16'(ifc0.mem_req), 16'h0000);
        chk("rst_pc_en",      16'(ifc0.pc_en), 16'h0000);
        chk("rst_inst_valid", 16'(ifc0.inst_valid), 16'h0000);
        chk("rst_inst",       ifc0.inst, 16'h0000);
        chk("rst_inst_addr",  ifc0.inst_addr, 16'h0000);

        // First fetch from address 0, zero-wait memory
        rst = 1'b1;
        #1;
        chk("idle_mem_req", 16'(ifc0.mem_req), 16'h0000);
        tick();
        chk("f0_req_lo", 16'(ifc0.mem_req), 16'h0001);
        chk("f0_addr_lo", ifc0.mem_addr, 16'h0000);
        tick();
        chk("f0_wait_lo_req", 16'(ifc0.mem_req), 16'h0000);
        tick();
        chk("f0_addr_hi", ifc0.mem_addr, 16'h0001);
        chk("f0_pc_en_hi", 16'(ifc0.pc_en), 16'h0000);
        tick();
        chk("f0_pc_en_wait_hi", 16'(ifc0.pc_en), 16'h0001);
        tick();
        chk("f0_inst", ifc0.inst, 16'h1234);
        chk("f0_inst_addr", ifc0.inst_addr, 16'h0000);
        chk("f0_valid", 16'(ifc0.inst_valid), 16'h0001);

        // Decode stalls for 5 cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 16'(ifc0.inst_valid), 16'h0001);
            chk("stall_inst", ifc0.inst, 16'h1234);
            chk("stall_mem_req", 16'(ifc0.mem_req), 16'h0000);
            chk("stall_pc_en", 16'(ifc0.pc_en), 16'h0000);
            tick();
        end
        ifc0.inst_ready = 1'b1;
        ifc0.mem_gnt    = 1'b0;
        #1;
        chk("xfer_valid", 16'(ifc0.inst_valid), 16'h0001);
        tick();
        ifc0.inst_ready = 1'b0;
        #1;

        // Grant withheld 3 cycles in REQ_LO
        for (int i = 0; i < 3; i++) begin
            chk("nognt_req", 16'(ifc0.mem_req), 16'h0001);
            chk("nognt_addr", ifc0.mem_addr, 16'h0002);
            chk("nognt_pc_en", 16'(ifc0.pc_en), 16'h0000);
            tick();
        end
        ifc0.mem_gnt = 1'b1;
        #1;
        chk("gnt_req", 16'(ifc0.mem_req), 16'h0001);
        chk("gnt_addr", ifc0.mem_addr, 16'h0002);
        chk("gnt_pc_en", 16'(ifc0.pc_en), 16'h0000);
        tick();
        tick();
        chk("f1_addr_hi", ifc0.mem_addr, 16'h0003);
        tick();
        chk("f1_pc_en", 16'(ifc0.pc_en), 16'h0001);
        tick();
        chk("f1_inst_le", ifc0.inst, 16'h5678);
        chk("f1_inst_be", ifc1.inst, 16'h7856);
        chk("f1_inst_addr", ifc0.inst_addr, 16'h0002);

        // Flush together with inst_ready in HOLD
        target          = 16'h0080;
        ifc0.flush      = 1'b1;
        ifc0.inst_ready = 1'b1;
        #1;
        chk("fhold_valid", 16'(ifc0.inst_valid), 16'h0000);
        chk("fhold_pc_en", 16'(ifc0.pc_en), 16'h0001);
        tick();
        ifc0.flush      = 1'b0;
        ifc0.inst_ready = 1'b0;
        #1;
        chk("fhold_pc_en_after", 16'(ifc0.pc_en), 16'h0000);
        chk("fhold_req", 16'(ifc0.mem_req), 16'h0001);
        chk("fhold_addr", ifc0.mem_addr, 16'h0080);
        tick();
        tick();
        rv_hold = 1'b1;
        tick();

        // Flush in WAIT_HI before rvalid: drain the late byte
        chk("fwait_pc_en_pre", 16'(ifc0.pc_en), 16'h0000);
        target     = 16'h0040;
        ifc0.flush = 1'b1;
        #1;
        chk("fwait_pc_en", 16'(ifc0.pc_en), 16'h0001);
        chk("fwait_valid", 16'(ifc0.inst_valid), 16'h0000);
        tick();
        ifc0.flush = 1'b0;
        #1;
        chk("drain_req", 16'(ifc0.mem_req), 16'h0000);
        chk("drain_pc_en", 16'(ifc0.pc_en), 16'h0000);
        chk("drain_valid", 16'(ifc0.inst_valid), 16'h0000);
        tick();
        rv_hold = 1'b0;
        mem_drive();
        #1;
        chk("drain_rv_req", 16'(ifc0.mem_req), 16'h0000);
        chk("drain_rv_valid", 16'(ifc0.inst_valid), 16'h0000);
        chk("drain_rv_pc_en", 16'(ifc0.pc_en), 16'h0000);
        tick();
        chk("redir_req", 16'(ifc0.mem_req), 16'h0001);
        chk("redir_addr", ifc0.mem_addr, 16'h0040);
        tick();
        tick();
        tick();
        tick();
        chk("f2_valid", 16'(ifc0.inst_valid), 16'h0001);
        chk("f2_inst", ifc0.inst, 16'h2211);
        chk("f2_inst_addr", ifc0.inst_addr, 16'h0040);

        // Redirect to 0xFFFF: second byte wraps to 0x0000
        target     = 16'hFFFF;
        ifc0.flush = 1'b1;
        tick();
        ifc0.flush    = 1'b0;
        mem[16'h0000] = 8'hCD;
        #1;
        chk("wrap_addr_lo", ifc0.mem_addr, 16'hFFFF);
        tick();
        tick();
        chk("wrap_req_hi", 16'(ifc0.mem_req), 16'h0001);
        chk("wrap_addr_hi", ifc0.mem_addr, 16'h0000);
        tick();
        tick();
        chk("wrap_inst_le", ifc0.inst, 16'hCDAB);
        chk("wrap_inst_be", ifc1.inst, 16'hABCD);
        chk("wrap_inst_addr", ifc0.inst_addr, 16'hFFFF);

        // Reset with a read outstanding; the stale rvalid after release is ignored
        ifc0.inst_ready = 1'b1;
        tick();
        ifc0.inst_ready = 1'b0;
        #1;
        chk("pre_rst_addr", ifc0.mem_addr, 16'h0001);
        rv_hold = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 16'(ifc0.mem_req), 16'h0000);
        tick();
        chk("mid_rst_inst", ifc0.inst, 16'h0000);
        chk("mid_rst_inst_addr", ifc0.inst_addr, 16'h0000);
        chk("mid_rst_valid", 16'(ifc0.inst_valid), 16'h0000);
        rst     = 1'b1;
        rv_hold = 1'b0;
        mem_drive();
        #1;
        chk("stale_rv_req", 16'(ifc0.mem_req), 16'h0000);
        tick();
        chk("post_rst_req", 16'(ifc0.mem_req), 16'h0001);
        chk("post_rst_addr", ifc0.mem_addr, 16'h0001);
        tick();
        tick();
        chk("post_rst_addr_hi", ifc0.mem_addr, 16'h0002);
        tick();
        tick();
        chk("post_rst_valid", 16'(ifc0.inst_valid), 16'h0001);
        chk("post_rst_inst", ifc0.inst, 16'h7812);
        chk("post_rst_inst_addr", ifc0.inst_addr, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have one parameter: BIG_ENDIAN, default 0, byte order of an instruction in memory (0: first byte is bits [7:0]; 1: first byte is bits [15:8]).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port pc_addr, input, 16 bits: current PC value; changes only at the clock edge after a cycle with pc_en=1.
REQ-005 The block SHALL have the port pc_en, output, 1 bit: request to the PC to advance (pc+2) or load the branch target.
REQ-006 The block SHALL have the port flush, input, 1 bit: branch redirect; abandons the current fetch.
REQ-007 The block SHALL have the port mem_req, output, 1 bit: byte read request.
REQ-008 The block SHALL have the port mem_addr, output, 16 bits: byte address of the read.
REQ-009 The block SHALL have the port mem_gnt, input, 1 bit: request accepted this cycle.
REQ-010 The block SHALL have the port mem_rvalid, input, 1 bit: read data valid; at least 1 cycle after gnt; in order; at most one outstanding.
REQ-011 The block SHALL have the port mem_rdata, input, 8 bits: read byte.
REQ-012 The block SHALL have the port inst_valid, output, 1 bit: instruction available to decode.
REQ-013 The block SHALL have the port inst, output, 16 bits: fetched instruction.
REQ-014 The block SHALL have the port inst_addr, output, 16 bits: address of inst.
REQ-015 The block SHALL have the port inst_ready, input, 1 bit: decode accepts inst; a transfer occurs when inst_valid=1 and inst_ready=1.

Function
REQ-016 FSM states SHALL be IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, HOLD and DRAIN.
REQ-017 IDLE SHALL move to REQ_LO unconditionally after one cycle.
REQ-018 REQ_LO behaviour: mem_req=1; mem_addr=pc_addr; on mem_gnt, fetch_addr<=pc_addr and go to WAIT_LO; otherwise hold the request.
REQ-019 WAIT_LO behaviour: on mem_rvalid, store the first byte and go to REQ_HI.
REQ-020 REQ_HI behaviour: mem_req=1; mem_addr=fetch_addr+1 (16-bit wrap, 16'hFFFF+1=16'h0000); on mem_gnt go to WAIT_HI.
REQ-021 WAIT_HI behaviour: on mem_rvalid, register inst (byte order per BIG_ENDIAN) and inst_addr=fetch_addr, assert pc_en combinationally in that same cycle, and go to HOLD.
REQ-022 HOLD behaviour: inst_valid=1 with inst and inst_addr stable; on transfer go to REQ_LO.
REQ-023 Steady state SHALL take 4 cycles per instruction with zero-wait memory (gnt in the request cycle, rvalid the next cycle) plus at least 1 HOLD cycle.
REQ-024 mem_req SHALL be 0 in every state except REQ_LO and REQ_HI; mem_addr SHALL be don't-care when mem_req=0.
REQ-025 pc_en SHALL be a single-cycle pulse per completed or flushed fetch, and SHALL never be asserted in any other cycle.
REQ-026 Flush SHALL force pc_en=1 in that cycle, take priority over every other event, and force inst_valid=0 combinationally, so a HOLD instruction is never transferred during flush.
REQ-027 Flush next-state: an outstanding read whose rvalid has not yet arrived (WAIT_LO/WAIT_HI without rvalid, or REQ_LO/REQ_HI with gnt in the same cycle) SHALL go to DRAIN; all other flush cases SHALL go to REQ_LO.
REQ-028 DRAIN SHALL discard data on mem_rvalid and go to REQ_LO; a flush while in DRAIN SHALL pulse pc_en and remain in DRAIN until mem_rvalid.
REQ-029 mem_rvalid received in any state other than WAIT_LO, WAIT_HI or DRAIN SHALL be ignored.

Reset
REQ-030 While rst=0 at a clock edge: state<=IDLE; inst_valid, pc_en, mem_req SHALL be 0; inst, inst_addr, fetch_addr SHALL be 16'h0000; the stored byte SHALL be 8'h00.
REQ-031 Reset SHALL take effect mid-fetch, including with a read outstanding; rvalid arriving after reset release SHALL be ignored per REQ-029.

Verification
REQ-032 Bench SHALL cover reset release with pc_addr=0, zero-wait memory holding bytes 0x34 at address 0 and 0x12 at address 1, BIG_ENDIAN=0 -> inst=16'h1234, inst_addr=0, pc_en one pulse in the WAIT_HI cycle.
REQ-033 Bench SHALL cover mem_gnt held low 3 cycles in REQ_LO -> mem_req and mem_addr stable for 4 cycles, pc_en=0 throughout.
REQ-034 Bench SHALL cover HOLD with inst_ready=0 for 5 cycles -> inst_valid=1 and inst stable, no memory request, pc_en=0; then inst_ready=1 -> REQ_LO next cycle with mem_addr equal to the new pc_addr (old value + 2).
REQ-035 Bench SHALL cover flush in WAIT_HI before rvalid -> pc_en=1 that cycle, DRAIN, late rvalid byte discarded, next mem_addr equals branch target 16'h0040, no inst_valid from the flushed fetch.
REQ-036 Bench SHALL cover flush and inst_ready together in HOLD -> inst_valid=0 that cycle, single pc_en pulse, next fetch from the branch target.
REQ-037 Bench SHALL cover fetch at pc_addr=16'hFFFF -> second request addresses 16'h0000; BIG_ENDIAN=1 with bytes 0xAB,0xCD -> inst=16'hABCD.
